ripple_count_sampler: RTL
=========================

# ripple_count_sampler

Downstream consumer of the 4-bit asynchronous ripple up-counter. Brings the counter's ripple-settling, clock-asynchronous `count` bus into the system clock domain and filters out transient ripple codes. Publishes a settled value with a one-cycle update strobe, extends it with a wrap counter, and flags any transition that is not a +1 step.

## Interface
Parameters:
- `WIDTH`, 4: width of the sampled counter bus.
- `STABLE_CYCLES`, 2: consecutive identical synchronized samples required before a value is accepted; legal range 1–15.
- `WRAP_W`, 12: width of the wrap (overflow) counter.

Ports:
- `clk`, input, 1: system clock; all state on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset; clears all state immediately.
- `count_in`, input, WIDTH: ripple counter output, asynchronous to `clk`.
- `count_q`, output, WIDTH: last accepted settled value.
- `upd`, output, 1: one-cycle pulse when `count_q` takes a new value.
- `wrap`, output, 1: one-cycle pulse, coincident with `upd`, on an accepted max→0 step.
- `ext_count`, output, WRAP_W+WIDTH: `{wrap_cnt, count_q}`.
- `seq_err`, output, 1: sticky flag for a non-+1 step; cleared only by `rst`.

## Operation
- **Synchronizer**: two flops per bit (`s1`, `s2`). No combinational path from `count_in` to any output.
- **Stability filter**: hold register `h` and run counter `run`, saturating at STABLE_CYCLES.
  - If `s2 == h`, `run` increments.
  - Otherwise `h <= s2` and `run <= 1`.
  - A candidate is valid on the cycle `run` first reaches STABLE_CYCLES.
- **FSM states**:
  - SYNC is the reset state. The first valid candidate loads `count_q`, pulses `upd`, does not touch `wrap_cnt`, performs no sequence check, and moves to TRACK.
  - TRACK: a valid candidate equal to `count_q` is ignored. A differing candidate loads `count_q` and pulses `upd`, then:
    - candidate == `count_q`+1 mod 2^WIDTH with `count_q` == 2^WIDTH−1: pulse `wrap`, increment `wrap_cnt`.
    - candidate == `count_q`+1 with no rollover: plain update.
    - any other value: sequence error (see Configuration). `count_q` still loads the candidate, and `wrap_cnt` is unchanged.
- `wrap_cnt` wraps modulo 2^WRAP_W with no saturation and no flag.
- A value that changes before reaching STABLE_CYCLES restarts the filter and is never accepted.

## Timing
- Reset values: `count_q`=0, `upd`=0, `wrap`=0, `ext_count`=0, `seq_err`=0. Also `s1`, `s2`, `h`, `run`, `wrap_cnt` = 0, and the FSM is in SYNC.
- Latency: `count_in` settled before clk edge k (sampled into `s1` at k). `upd`, `wrap` and the new `count_q` are visible after edge k+1+STABLE_CYCLES (defaults: 3 cycles after the sampling edge).
- Throughput: at most one accepted update per STABLE_CYCLES cycles. An upstream counter stepping faster than 2+STABLE_CYCLES `clk` cycles may skip codes and raise `seq_err`. This is defined behaviour, not a bug.
- `upd` and `wrap` are registered single-cycle pulses and never assert in consecutive cycles when STABLE_CYCLES ≥ 2.
- Reset mid-operation: outputs clear asynchronously. After release the block re-enters SYNC, and the first accepted value sets no `wrap` and no `seq_err`.
- Reset release is synchronized externally; the block does not re-synchronize `rst`.

## Configuration
- Macro `RIPPLE_SAMPLER_SEQ_CHECK_EN`.
- Defined: the +1 sequence check is built. A non-+1 step in TRACK sets `seq_err` on the same edge as `upd`.
- Undefined: check logic is omitted, `seq_err` is tied to 0, and all other behaviour (including wrap detection) is identical.

## Structure
- Package `ripple_sampler_pkg`:
  - state enum `samp_state_t` {SAMP_SYNC, SAMP_TRACK};
  - default localparams for WIDTH, STABLE_CYCLES, WRAP_W.
- Sub-module `sync_2ff`: parameterized-width two-flop synchronizer with async active-high reset to 0, instantiated once at WIDTH.
- Top holds the filter, FSM, wrap counter and checker.

## Test plan
- **Reset / first value**: `rst`=1, then `count_in`=5 steady and `rst` released → `count_q`=0 during reset. One `upd` 3 cycles after the first sampling edge, `count_q`=5, `seq_err`=0, `wrap_cnt`=0.
- **Clean counting**: step `count_in` 0→15→0 every 10 cycles → 16 `upd` pulses, a single `wrap` on 15→0, and `ext_count`=0x010 after the 0 is accepted.
- **Ripple glitch**: hold 7, drive 6 for 1 cycle, then 8 → 6 is never accepted; `count_q` goes 7→8 with no `seq_err`.
- **Skip**: `count_q`=3, drive 5 steady → `upd`, `count_q`=5, `seq_err`=1 and sticky. With the macro undefined, `seq_err` stays 0.
- **Reset mid-operation**: with `wrap_cnt`=2, assert `rst` mid-cycle → all outputs 0 immediately. After release the first value is accepted with no `wrap` or `seq_err`.
- **Wrap-counter rollover**: WRAP_W=2, 4 full count cycles → `wrap_cnt` returns to 0 with no flag.

Source files
------------

// File: rtl/ripple_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_sampler_pkg
//  Description : Shared types and default parameters for the ripple counter
//                sampler (state encoding, default bus widths, filter depth).
//  Optional    : none in this file (the sampler itself honours
//                RIPPLE_SAMPLER_SEQ_CHECK_EN).
//  Revision    : 1.0  initial release
// ============================================================================
package ripple_sampler_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_WRAP_W        = 12;

    // SYNC: waiting for the first settled value (no sequence reference yet).
    // TRACK: every accepted change is checked against the previous value.
    typedef enum logic [0:0] {
        SAMP_SYNC  = 1'b0,
        SAMP_TRACK = 1'b1
    } samp_state_t;

endpackage : ripple_sampler_pkg
`default_nettype wire

// File: rtl/ripple_count_sampler_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Parameterised-width two-flop synchronizer. Each bit is
//                synchronized independently; bus coherence is restored by the
//                stability filter downstream.
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-high reset, clears both stages
//                d_i  - asynchronous input bus
//                q_o  - synchronized bus (second stage)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_count_sampler
//  Description : Samples the output of an asynchronous 4-bit ripple counter
//                into the clk domain, rejects transient ripple codes with a
//                stability filter, publishes the settled value with an update
//                strobe, extends it with a wrap counter and flags non-+1 steps.
//  Ports       : clk       - system clock (rising edge)
//                rst       - asynchronous active-high reset
//                count_in  - ripple counter bus, asynchronous to clk
//                count_q   - last accepted settled value
//                upd       - one-cycle pulse when count_q takes a new value
//                wrap      - one-cycle pulse with upd on an accepted max->0 step
//                ext_count - {wrap counter, count_q}
//                seq_err   - sticky non-+1 step flag, cleared only by rst
//  Optional    : define RIPPLE_SAMPLER_SEQ_CHECK_EN to build the +1 sequence
//                check; otherwise seq_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module ripple_count_sampler
    import ripple_sampler_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,  // legal 1..15
    parameter int WRAP_W        = DEF_WRAP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        count_in,
    output logic [WIDTH-1:0]        count_q,
    output logic                    upd,
    output logic                    wrap,
    output logic [WRAP_W+WIDTH-1:0] ext_count,
    output logic                    seq_err
);

    localparam logic [3:0] RUN_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] RUN_LAST = 4'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_s2;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (count_in),
        .q_o (w_s2)
    );

    // The synchronizer's reset zeros are not real samples of count_in. Two
    // priming flops hold the filter idle until the second stage carries a
    // genuine sample, so a reset-time 0 can never be accepted ahead of the
    // real counter value.
    logic [1:0] prime_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_q <= 2'b00;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] h_d;
    logic [3:0]       run_q;
    logic [3:0]       run_d;
    logic             w_cand_vld;

    // A candidate is valid on the edge where run first reaches RUN_MAX; the
    // candidate itself is the current s2 value (equal to h when matching).
    always_comb begin
        h_d        = h_q;
        run_d      = run_q;
        w_cand_vld = 1'b0;
        if (prime_q[1]) begin
            if (w_s2 == h_q) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + 4'd1;
                end
                w_cand_vld = (run_q == RUN_LAST);
            end else begin
                h_d        = w_s2;
                run_d      = 4'd1;
                w_cand_vld = (RUN_MAX == 4'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q   <= '0;
            run_q <= 4'd0;
        end else begin
            h_q   <= h_d;
            run_q <= run_d;
        end
    end

    // ------------------------------------------------------------------
    // Acceptance FSM, wrap counter
    // ------------------------------------------------------------------
    samp_state_t       state_q;
    samp_state_t       state_d;
    logic [WIDTH-1:0]  count_d;
    logic              upd_q;
    logic              upd_d;
    logic              wrap_q;
    logic              wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_d;

    logic [WIDTH-1:0]  w_next_exp;
    logic              w_is_step;
    logic              w_at_max;

    assign w_next_exp = count_q + WIDTH'(1);
    assign w_is_step  = (w_s2 == w_next_exp);
    assign w_at_max   = (count_q == {WIDTH{1'b1}});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        upd_d      = 1'b0;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (w_cand_vld) begin
            case (state_q)
                SAMP_SYNC: begin
                    count_d = w_s2;
                    upd_d   = 1'b1;
                    state_d = SAMP_TRACK;
                end
                SAMP_TRACK: begin
                    if (w_s2 != count_q) begin
                        count_d = w_s2;
                        upd_d   = 1'b1;
                        // wrap_cnt rolls over modulo 2^WRAP_W silently
                        if (w_is_step && w_at_max) begin
                            wrap_d     = 1'b1;
                            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SAMP_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SAMP_SYNC;
            count_q    <= '0;
            upd_q      <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            upd_q      <= upd_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign upd       = upd_q;
    assign wrap      = wrap_q;
    assign ext_count = {wrap_cnt_q, count_q};

    // ------------------------------------------------------------------
    // Sequence checker
    // ------------------------------------------------------------------
`ifdef RIPPLE_SAMPLER_SEQ_CHECK_EN
    logic w_seq_hit;
    logic seq_err_q;

    // Only TRACK has a reference value; the first accepted value after reset
    // is never judged.
    assign w_seq_hit = w_cand_vld && (state_q == SAMP_TRACK) &&
                       (w_s2 != count_q) && !w_is_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_q <= 1'b0;
        end else if (w_seq_hit) begin
            seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule : ripple_count_sampler
`default_nettype wire
